// File: rtl/i2c_master_ctrl_pkg.sv
// i2c_master_ctrl_pkg: shared FSM states and slot constants for the I2C master
package i2c_master_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MACK, STOP
  } state_t;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;
  localparam int DEFAULT_DIVIDE_BY = 4;
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: per-bit-slot phase counter giving SCL level, sample point and slot end
module i2c_phase_gen
  import i2c_master_ctrl_pkg::*;
#(
  parameter int DIVIDE_BY = DEFAULT_DIVIDE_BY
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_scl_level,
  output logic o_sample_tick,
  output logic o_slot_end,
  output logic o_late
);
  localparam int PW = $clog2(DIVIDE_BY);
  logic [PW-1:0] r_phase;
  always_ff @(posedge clk) begin
    if (rst || !i_run) r_phase <= '0;
    else r_phase <= (r_phase == PW'(DIVIDE_BY - 1)) ? '0 : r_phase + PW'(1);
  end
  assign o_scl_level   = i_run && (r_phase >= PW'(DIVIDE_BY / 2));
  assign o_sample_tick = i_run && (r_phase == PW'(3 * DIVIDE_BY / 4));
  assign o_slot_end    = i_run && (r_phase == PW'(DIVIDE_BY - 1));
  assign o_late        = i_run && (r_phase >= PW'(3 * DIVIDE_BY / 4));
endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master issuing START/addr/data/STOP and returning read data
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter int DIVIDE_BY = DEFAULT_DIVIDE_BY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);
  state_t r_state, w_next;
  logic [7:0] r_shift, r_data, r_rx, r_dout;
  logic [2:0] r_bits;
  logic r_rw, r_ack;
  logic w_scl_level, w_sample, w_end, w_late, w_sda_in, w_ack;
  logic w_addr_done, w_data_done, w_sda_oe, w_sda_val, w_scl;

  i2c_phase_gen #(.DIVIDE_BY(DIVIDE_BY)) u_phase (
    .clk(clk),
    .rst(rst),
    .i_run(r_state != IDLE),
    .o_scl_level(w_scl_level),
    .o_sample_tick(w_sample),
    .o_slot_end(w_end),
    .o_late(w_late)
  );

  assign w_sda_in    = i2c_sda;
  // with small dividers the sample point is also the slot's last cycle
  assign w_ack       = w_sample ? w_sda_in : r_ack;
  assign w_addr_done = r_bits == 3'(ADDR_BITS - 1);
  assign w_data_done = r_bits == 3'(DATA_BITS - 1);

  always_comb begin
    w_next    = r_state;
    w_sda_oe  = 1'b1;
    w_sda_val = 1'b1;
    w_scl     = w_scl_level;
    unique case (r_state)
      IDLE: begin
        w_scl  = 1'b1;
        w_next = enable ? START : IDLE;
      end
      START: begin
        w_scl     = 1'b1;
        w_sda_val = !w_scl_level;
        w_next    = w_end ? ADDR : START;
      end
      ADDR: begin
        w_sda_val = r_shift[7];
        w_next    = (w_end && w_addr_done) ? ADDR_ACK : ADDR;
      end
      ADDR_ACK: begin
        w_sda_oe = 1'b0;
        w_next   = !w_end ? ADDR_ACK : w_ack ? STOP : r_rw ? RDATA : WDATA;
      end
      WDATA: begin
        w_sda_val = r_shift[7];
        w_next    = (w_end && w_data_done) ? WDATA_ACK : WDATA;
      end
      WDATA_ACK: begin
        w_sda_oe = 1'b0;
        w_next   = w_end ? STOP : WDATA_ACK;
      end
      RDATA: begin
        w_sda_oe = 1'b0;
        w_next   = (w_end && w_data_done) ? MACK : RDATA;
      end
      MACK: w_next = w_end ? STOP : MACK;
      STOP: begin
        w_sda_val = w_late;
        w_next    = w_end ? IDLE : STOP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_bits  <= '0;
      r_rw    <= 1'b0;
      r_ack   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && enable) begin
        r_shift <= {addr, rw};
        r_data  <= data_in;
        r_rw    <= rw;
        r_bits  <= '0;
      end
      if (w_sample && r_state == ADDR_ACK) r_ack <= w_sda_in;
      if (w_sample && r_state == RDATA) r_rx <= {r_rx[6:0], w_sda_in};
      if (w_end && (r_state == ADDR || r_state == WDATA || r_state == RDATA)) r_bits <= r_bits + 3'd1;
      if (w_end && (r_state == ADDR || r_state == WDATA)) r_shift <= {r_shift[6:0], 1'b0};
      if (w_end && r_state == ADDR_ACK) r_shift <= r_data;
      if (w_end && r_state == MACK) r_dout <= r_rx;
    end
  end

  assign i2c_sda  = w_sda_oe ? w_sda_val : 1'bz;
  assign i2c_scl  = w_scl;
  assign ready    = r_state == IDLE;
  assign data_out = r_dout;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: random and directed transactions against a bus-level slave/monitor model
module tb_i2c_master_ctrl;
  localparam int D = 4;
  localparam logic [6:0] SLV = 7'h2A;

  logic clk = 1'b0;
  logic rst, enable, rw, ready;
  logic [6:0] addr;
  logic [7:0] data_in, data_out;
  wire sda, scl;
  logic s_low = 1'b0;
  assign sda = s_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master_ctrl #(.DIVIDE_BY(D)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .data_in(data_in),
    .enable(enable),
    .rw(rw),
    .data_out(data_out),
    .ready(ready),
    .i2c_sda(sda),
    .i2c_scl(scl)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int starts = 0, stops = 0, edges = 0, busy_cyc = 0;
  bit q[$];
  bit last[$];
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] exp_dout = 8'h00;
  logic p_sda = 1'b1, p_scl = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // slave at SLV: ACKs its address, ACKs written data, returns rd_byte on reads
  function automatic logic slave_drive(int n);
    logic [7:0] a;
    if (n < 8) return 1'b0;
    for (int i = 0; i < 8; i++) a[7-i] = q[i];
    if (a[7:1] != SLV) return 1'b0;
    if (n == 8) return 1'b1;
    if (a[0] && n >= 9 && n <= 16) return !rd_byte[16-n];
    if (!a[0] && n == 17) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] byte_at(int off);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b[7-i] = (off + i < last.size()) ? last[off+i] : 1'b0;
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      s_low = 1'b0;
    end else if (p_scl && scl && p_sda && !sda) begin
      q.delete();
      starts++;
    end else if (p_scl && scl && !p_sda && sda) begin
      last = q;
      stops++;
    end else if (!p_scl && scl) q.push_back(sda);
    else if (p_scl && !scl) s_low = slave_drive(q.size());
    if (sda !== p_sda || scl !== p_scl) edges++;
    p_sda = sda;
    p_scl = scl;
  end

  always @(negedge clk) if (!rst && !ready) busy_cyc++;

  task automatic txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                     input logic [7:0] rb, input int hold, input bit poke);
    int s0, t0;
    bit m;
    m = (a == SLV);
    rd_byte = rb;
    @(negedge clk);
    s0 = stops;
    t0 = starts;
    busy_cyc = 0;
    addr = a; rw = r; data_in = d; enable = 1'b1;
    repeat (hold) @(negedge clk);
    enable = 1'b0;
    if (poke) begin
      repeat (2 * D) @(negedge clk);
      addr = ~a; rw = ~r; data_in = ~d; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
    for (int i = 0; i < 400 && !ready; i++) @(negedge clk);
    chk("ready_back", ready, 1'b1);
    repeat (4) @(negedge clk);
    chk("one_start", starts - t0, 1);
    chk("one_stop", stops - s0, 1);
    chk("busy_cycles", busy_cyc, (m ? 20 : 11) * D);
    chk("addr_byte", byte_at(0), {a, r});
    chk("addr_ack", last[8], !m);
    chk("scl_pulses", last.size(), m ? 19 : 10);
    if (m && !r) begin
      chk("wdata_byte", byte_at(9), d);
      chk("wdata_ack", last[17], 1'b0);
    end
    if (m && r) begin
      chk("rdata_byte", byte_at(9), rb);
      chk("master_nack", last[17], 1'b1);
      exp_dout = rb;
    end
    chk("data_out", data_out, exp_dout);
  endtask

  initial begin
    logic [6:0] ra;
    int s0;
    rst = 1'b1; enable = 1'b0; addr = '0; rw = 1'b0; data_in = '0;
    repeat (5) @(negedge clk);
    edges = 0;
    repeat (45) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_sda", sda, 1'b1);
    chk("rst_scl", scl, 1'b1);
    chk("rst_quiet", edges, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    txn(SLV, 1'b0, 8'hAA, 8'h00, 5, 1'b0);
    txn(SLV, 1'b1, 8'h00, 8'h5C, 1, 1'b0);
    txn(7'h11, 1'b0, 8'h33, 8'h00, 1, 1'b0);
    txn(7'h11, 1'b1, 8'h33, 8'hFF, 1, 1'b0);
    txn(SLV, 1'b0, 8'h3C, 8'h00, 1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      ra = $urandom_range(0, 1) ? SLV : 7'($urandom);
      txn(ra, 1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3), 1'($urandom));
    end
    txn(SLV, 1'b1, 8'h00, 8'hC3, 1, 1'b0);

    @(negedge clk);
    s0 = stops;
    addr = SLV; rw = 1'b0; data_in = 8'h96; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (12 * D + 1) @(negedge clk);
    chk("mid_busy", ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", ready, 1'b1);
    chk("mid_sda", sda, 1'b1);
    chk("mid_scl", scl, 1'b1);
    chk("mid_dout", data_out, 8'h00);
    exp_dout = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_stop", stops - s0, 0);

    txn(SLV, 1'b0, 8'h81, 8'h00, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
